des_key_sched_iter: RTL and testbench

DES_KEY_SCHED_ITER -- requirements
Module: des_key_sched_iter

---
 rtl/des_key_sched_iter.sv | 160 ++++++++++++++++
 tb/tb_des_key_sched_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_iter.sv
// Iterative DES/3DES key schedule: emits one PC-2 round key per handshake from a
// single rotating C/D pair, for NUM_KEYS keys in encrypt or decrypt order.
module des_key_sched_iter #(
    parameter int NUM_KEYS       = 3,
    parameter bit BIT_ORDER_MSB0 = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [0:64*NUM_KEYS-1]  Sk,
    input  logic                    is_encrypt,
    output logic                    ready,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [0:47]             rk_data,
    output logic [1:0]              rk_key_idx,
    output logic [3:0]              rk_round,
    output logic                    done
);

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t                   state, state_next;
    logic [0:64*NUM_KEYS-1]   key_reg;
    logic [0:64*NUM_KEYS-1]   src_bundle;
    logic                     enc_reg;
    logic [0:27]              c_reg, d_reg;
    logic [0:63]              key_sel;
    logic [0:55]              pc1_cd;
    logic [0:27]              load_c, load_d, step_c, step_d;
    logic [1:0]               first_idx, next_idx, load_idx;
    logic [3:0]               round_next;
    logic                     load_enc, accept, handshake, last_key, last_round;

    // FIPS bit n (1-based) of a key, honouring the configured bit numbering
    function automatic logic key_bit(input logic [0:63] key, input int n);
        return BIT_ORDER_MSB0 ? key[6'(n - 1)] : key[6'(64 - n)];
    endfunction

    function automatic logic [0:55] pc1(input logic [0:63] key);
        logic [0:55] cd;
        for (int i = 0; i < 56; i++)
            cd[6'(i)] = key_bit(key, PC1_TAB[i]);
        return cd;
    endfunction

    function automatic logic [0:47] pc2(input logic [0:27] c, input logic [0:27] d);
        logic [0:55] cd;
        logic [0:47] k;
        cd = {c, d};
        for (int i = 0; i < 48; i++)
            k[6'(BIT_ORDER_MSB0 ? i : 47 - i)] = cd[6'(PC2_TAB[i] - 1)];
        return k;
    endfunction

    function automatic logic two_step(input logic [3:0] r);
        return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
    endfunction

    function automatic logic [0:27] rot_left(input logic [0:27] x, input logic two);
        return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
    endfunction

    function automatic logic [0:27] rot_right(input logic [0:27] x, input logic two);
        return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
    endfunction

    assign accept     = (state == IDLE) && start;
    assign handshake  = (state == GEN) && rk_ready;
    assign last_round = (rk_round == 4'd15);
    assign last_key   = enc_reg ? (rk_key_idx == 2'(NUM_KEYS - 1)) : (rk_key_idx == 2'd0);
    assign first_idx  = is_encrypt ? 2'd0 : 2'(NUM_KEYS - 1);
    assign next_idx   = enc_reg ? rk_key_idx + 2'd1 : rk_key_idx - 2'd1;
    assign round_next = rk_round + 4'd1;

    // On start the key comes straight from the port since key_reg loads on the same edge
    assign src_bundle = (state == IDLE) ? Sk : key_reg;
    assign load_idx   = accept ? first_idx : next_idx;
    assign load_enc   = accept ? is_encrypt : enc_reg;

    always_comb begin
        key_sel = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (load_idx == 2'(k))
                key_sel = src_bundle[64*k +: 64];
    end

    // Decrypt starts from the unrotated PC-1 value, which equals C16/D16
    always_comb begin
        pc1_cd = pc1(key_sel);
        load_c = load_enc ? rot_left(pc1_cd[0:27], 1'b0)  : pc1_cd[0:27];
        load_d = load_enc ? rot_left(pc1_cd[28:55], 1'b0) : pc1_cd[28:55];
        step_c = enc_reg ? rot_left(c_reg, two_step(round_next))
                         : rot_right(c_reg, two_step(4'd0 - round_next));
        step_d = enc_reg ? rot_left(d_reg, two_step(round_next))
                         : rot_right(d_reg, two_step(4'd0 - round_next));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = GEN;
            GEN:     if (handshake && last_round && last_key) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg    <= '0;
            enc_reg    <= 1'b0;
            c_reg      <= '0;
            d_reg      <= '0;
            rk_key_idx <= 2'd0;
            rk_round   <= 4'd0;
        end else if (accept) begin
            key_reg    <= Sk;
            enc_reg    <= is_encrypt;
            rk_key_idx <= first_idx;
            rk_round   <= 4'd0;
            c_reg      <= load_c;
            d_reg      <= load_d;
        end else if (handshake) begin
            if (!last_round) begin
                rk_round <= round_next;
                c_reg    <= step_c;
                d_reg    <= step_d;
            end else if (!last_key) begin
                rk_key_idx <= next_idx;
                rk_round   <= 4'd0;
                c_reg      <= load_c;
                d_reg      <= load_d;
            end
        end
    end

    assign ready    = (state == IDLE);
    assign rk_valid = (state == GEN);
    assign done     = (state == DONE);
    assign rk_data  = rk_valid ? pc2(c_reg, d_reg) : 48'd0;

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Scoreboard bench for des_key_sched_iter (3 keys): expected round keys come from an
// independent cumulative-shift model and are popped on every rk_valid&rk_ready.
module tb_des_key_sched_iter;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

    typedef struct packed {
        logic [1:0]  idx;
        logic [3:0]  rnd;
        logic [47:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, is_encrypt, rk_ready;
    logic [0:191]  Sk;
    logic          ready, rk_valid, done;
    logic [0:47]   rk_data;
    logic [1:0]    rk_key_idx;
    logic [3:0]    rk_round;

    int            tests_run = 0;
    int            fail_count = 0;
    int            handshakes = 0;
    int            done_count = 0;
    int            job_hs0 = 0;
    exp_t          exp_q [$];
    logic [63:0]   job_keys [3];
    logic          capture_first = 1'b0;
    logic [47:0]   first_data, last_data;
    logic          stalled = 1'b0;
    logic [53:0]   held;

    des_key_sched_iter #(.NUM_KEYS(3), .BIT_ORDER_MSB0(1)) dut (
        .clk(clk), .rst(rst), .start(start), .Sk(Sk), .is_encrypt(is_encrypt),
        .ready(ready), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_key_idx(rk_key_idx), .rk_round(rk_round), .done(done));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Subkey for round r: C/D taken from PC-1 and rotated by the total shift up to r
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input int r);
        logic        c0 [28];
        logic        d0 [28];
        logic        cd [56];
        logic [47:0] res;
        int          tot = 0;
        for (int i = 0; i <= r; i++)
            tot += (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
        for (int j = 0; j < 28; j++) begin
            c0[j] = key[6'(64 - PC1[j])];
            d0[j] = key[6'(64 - PC1[28 + j])];
        end
        for (int j = 0; j < 28; j++) begin
            cd[j]      = c0[(j + tot) % 28];
            cd[28 + j] = d0[(j + tot) % 28];
        end
        for (int j = 0; j < 48; j++)
            res[6'(47 - j)] = cd[PC2[j] - 1];
        return res;
    endfunction

    always @(negedge clk) begin
        if (!rst && rk_valid) begin
            if (stalled)
                checkOutput("stall_hold", 64'({rk_key_idx, rk_round, rk_data}), 64'(held));
            if (rk_ready) begin
                checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0)
                    checkOutput("round_key", 64'({rk_key_idx, rk_round, rk_data}),
                                64'(exp_q.pop_front()));
                if (capture_first) begin
                    first_data    = rk_data;
                    capture_first = 1'b0;
                end
                last_data = rk_data;
                handshakes++;
            end
            stalled = !rk_ready;
            held    = {rk_key_idx, rk_round, rk_data};
        end else begin
            stalled = 1'b0;
        end
        if (done) done_count++;
    end

    task automatic random_keys();
        for (int k = 0; k < 3; k++)
            job_keys[k] = {$urandom, $urandom};
    endtask

    task automatic launch_job(input logic enc);
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            int kidx = enc ? p : 2 - p;
            for (int r = 0; r < 16; r++) begin
                e.idx  = 2'(kidx);
                e.rnd  = 4'(r);
                e.data = model_subkey(job_keys[kidx], enc ? r : 15 - r);
                exp_q.push_back(e);
            end
        end
        for (int k = 0; k < 3; k++)
            Sk[64*k +: 64] = job_keys[k];
        is_encrypt    = enc;
        start         = 1'b1;
        rk_ready      = 1'b1;
        job_hs0       = handshakes;
        capture_first = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("valid_after_start", 64'(rk_valid), 64'(1));
    endtask

    task automatic applyStimulus(input logic enc, input bit backpressure, input bit pulse_start);
        int cycles = 0;
        launch_job(enc);
        while (!done && cycles < 2000) begin
            rk_ready = backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse_start && cycles == 10) begin
                start      = 1'b1;
                is_encrypt = !enc;
                for (int w = 0; w < 6; w++) Sk[32*w +: 32] = $urandom;
            end
            if (pulse_start && cycles == 13) start = 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        checkOutput("done_seen", 64'(done), 64'(1));
        if (!backpressure)
            checkOutput("done_latency", 64'(cycles), 64'(48));
        checkOutput("valid_in_done", 64'(rk_valid), 64'(0));
        checkOutput("ready_in_done", 64'(ready), 64'(0));
        checkOutput("handshake_total", 64'(handshakes - job_hs0), 64'(48));
        checkOutput("sb_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
        checkOutput("ready_after_done", 64'(ready), 64'(1));
        checkOutput("done_single_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        int cycles;
        int done_snap;
        rst = 1'b1; start = 1'b0; is_encrypt = 1'b0; rk_ready = 1'b0; Sk = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'(ready), 64'(1));
        checkOutput("reset_valid", 64'(rk_valid), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_state_out", 64'({rk_key_idx, rk_round, rk_data}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Start coinciding with reset must not launch a job
        rst = 1'b1; start = 1'b1; is_encrypt = 1'b1; Sk = {6{$urandom}};
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        checkOutput("rst_start_ready", 64'(ready), 64'(1));
        checkOutput("rst_start_valid", 64'(rk_valid), 64'(0));
        @(posedge clk); #1;
        checkOutput("rst_start_still_idle", 64'(rk_valid), 64'(0));

        for (int k = 0; k < 3; k++) job_keys[k] = KAT_KEY;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("kat_enc_round0", 64'(first_data), 64'(48'h1B02EFFC7072));
        checkOutput("kat_enc_round15", 64'(last_data), 64'(48'hCB3D8B0E17F5));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("kat_dec_round0", 64'(first_data), 64'(48'hCB3D8B0E17F5));
        checkOutput("kat_dec_round15", 64'(last_data), 64'(48'h1B02EFFC7072));

        random_keys();
        applyStimulus(1'b0, 1'b0, 1'b0);
        random_keys();
        applyStimulus(1'b1, 1'b1, 1'b0);
        random_keys();
        applyStimulus(1'b0, 1'b1, 1'b1);
        random_keys();
        applyStimulus(1'b1, 1'b0, 1'b1);

        // Abort at key 1 round 7, then confirm a clean restart
        random_keys();
        launch_job(1'b1);
        cycles = 0;
        while ((handshakes - job_hs0) < 23 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("abort_point", 64'({rk_key_idx, rk_round}), 64'({2'd1, 4'd7}));
        rst = 1'b1; rk_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_valid", 64'(rk_valid), 64'(0));
        checkOutput("abort_ready", 64'(ready), 64'(1));
        checkOutput("abort_outputs", 64'({rk_key_idx, rk_round, rk_data}), 64'(0));
        exp_q.delete();
        done_snap = done_count;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(done_count - done_snap), 64'(0));
        random_keys();
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
